pipelined_cla_adder: RTL and testbench

PIPELINED_CLA_ADDER -- requirements
Module: pipelined_cla_adder

---
 rtl/pipelined_cla_adder.sv | 130 +++++++++++++
 tb/tb_pipelined_cla_adder.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_cla_adder.sv
// Two-stage carry-lookahead adder/subtractor with valid/ready handshake on both ports.
// Define CLA_SAT_EN to saturate the sum on signed overflow instead of wrapping.
module pipelined_cla_adder #(
  parameter int WIDTH = 32,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NG = WIDTH / GROUP;

  logic             s2_load;
  logic             s1_load;
  logic             s1_valid;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] p_in;
  logic [WIDTH-1:0] g_in;
  logic             c0_in;
  logic [NG-1:0]    gg_in;
  logic [NG-1:0]    gp_in;
  logic [WIDTH-1:0] s1_p;
  logic [WIDTH-1:0] s1_g;
  logic [NG-1:0]    s1_gg;
  logic [NG-1:0]    s1_gp;
  logic             s1_c0;
  logic [NG:0]      gc;
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s_raw;
  logic [WIDTH-1:0] s_fin;
  logic             ovf_c;

  assign s2_load  = !out_valid || out_ready;
  assign s1_load  = !s1_valid || s2_load;
  assign in_ready = s1_load;

  assign b_eff = sub ? ~b : b;
  assign c0_in = sub | cin;
  assign p_in  = a ^ b_eff;
  assign g_in  = a & b_eff;

  always_comb begin
    gg_in = '0;
    gp_in = '0;
    for (int i = 0; i < NG; i++) begin
      gp_in[i] = &p_in[GROUP*i +: GROUP];
      gg_in[i] = g_in[GROUP*i+3]
               | (p_in[GROUP*i+3] & g_in[GROUP*i+2])
               | (p_in[GROUP*i+3] & p_in[GROUP*i+2] & g_in[GROUP*i+1])
               | (p_in[GROUP*i+3] & p_in[GROUP*i+2] & p_in[GROUP*i+1] & g_in[GROUP*i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_p     <= '0;
      s1_g     <= '0;
      s1_gg    <= '0;
      s1_gp    <= '0;
      s1_c0    <= 1'b0;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_p  <= p_in;
        s1_g  <= g_in;
        s1_gg <= gg_in;
        s1_gp <= gp_in;
        s1_c0 <= c0_in;
      end
    end
  end

  // Group carry-ins come from the lookahead chain; only in-group carries ripple.
  always_comb begin
    gc    = '0;
    gc[0] = s1_c0;
    for (int i = 0; i < NG; i++) begin
      gc[i+1] = s1_gg[i] | (s1_gp[i] & gc[i]);
    end
    c = '0;
    for (int k = 0; k < WIDTH; k++) begin
      if (k % GROUP == 0) begin
        c[k] = gc[k/GROUP];
      end
      c[k+1] = s1_g[k] | (s1_p[k] & c[k]);
    end
    c[WIDTH] = gc[NG];
    s_raw = s1_p ^ c[WIDTH-1:0];
    ovf_c = c[WIDTH] ^ c[WIDTH-1];
`ifdef CLA_SAT_EN
    // On overflow both operands share a sign, and g of the top bit equals that sign.
    if (ovf_c) begin
      s_fin = s1_g[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      s_fin = s_raw;
    end
`else
    s_fin = s_raw;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        sum  <= s_fin;
        cout <= c[WIDTH];
        ovf  <= ovf_c;
      end
    end
  end

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Self-checking bench: 32-bit instance with directed and random streams, 4-bit instance exhaustive.
module tb_pipelined_cla_adder;

  typedef struct packed {
    logic [31:0] s;
    logic        co;
    logic        ov;
  } res32_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [31:0] a, b, sum;
  logic        in_valid4, in_ready4, cin4, sub4, out_valid4, out_ready4, cout4, ovf4;
  logic [3:0]  a4, b4, sum4;

  int checks = 0;
  int failures = 0;
  res32_t     q32[$];
  logic [5:0] q4[$];

  always #5 clk = ~clk;

  pipelined_cla_adder #(.WIDTH(32), .GROUP(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .cout(cout), .ovf(ovf)
  );

  pipelined_cla_adder #(.WIDTH(4), .GROUP(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .a(a4), .b(b4),
    .cin(cin4), .sub(sub4), .out_valid(out_valid4), .out_ready(out_ready4), .sum(sum4),
    .cout(cout4), .ovf(ovf4)
  );

  // Reference: plain integer arithmetic, signed range test for overflow.
  function automatic res32_t model32(input logic [31:0] x, input logic [31:0] y,
                                     input logic ci, input logic sb);
    longint ux, uy, ur, sx, sy, sr;
    res32_t r;
    ux = longint'(x);
    uy = longint'(y);
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (sb) begin
      ur   = ux - uy;
      sr   = sx - sy;
      r.co = (ux >= uy);
    end else begin
      ur   = ux + uy + longint'(ci);
      sr   = sx + sy + longint'(ci);
      r.co = ur[32];
    end
    r.s  = ur[31:0];
    r.ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
`ifdef CLA_SAT_EN
    if (r.ov) r.s = (sr > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
`endif
    return r;
  endfunction

  // Advances one cycle from a falling edge, recording handshakes seen at the next rising edge.
  task automatic step32(output bit ov_seen, output bit ir_seen, output res32_t obs,
                        output bit got, output bit empty_pop, output res32_t expv,
                        output bit acc, output int nq);
    #1;
    ov_seen   = out_valid;
    ir_seen   = in_ready;
    obs       = {sum, cout, ovf};
    nq        = q32.size();
    got       = 1'b0;
    empty_pop = 1'b0;
    expv      = '0;
    acc       = 1'b0;
    if (rst) begin
      q32.delete();
    end else begin
      if (out_valid && out_ready) begin
        got = 1'b1;
        if (q32.size() == 0) empty_pop = 1'b1;
        else expv = q32.pop_front();
      end
      if (in_valid && in_ready) begin
        acc = 1'b1;
        q32.push_back(model32(a, b, cin, sub));
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; a = $urandom; b = $urandom; out_ready = 1'b1;
    in_valid4 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++;
    if ({sum, cout, ovf} !== 34'd0) begin
      failures++; $display("FAIL reset_outputs: got sum=%h cout=%b ovf=%b expected all 0", sum, cout, ovf);
    end
    checks++;
    if (out_valid4 !== 1'b0) begin failures++; $display("FAIL reset_out_valid4: got %b expected 0", out_valid4); end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_valid4 = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++;
    if (in_ready4 !== 1'b1) begin failures++; $display("FAIL reset_in_ready4: got %b expected 1", in_ready4); end
    @(negedge clk);
  endtask

  task automatic test_ripple();
    out_ready = 1'b1; in_valid = 1'b1; a = 32'hFFFF_FFFF; b = 32'h0; cin = 1'b1; sub = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL ripple_accept: got in_ready=%b expected 1", in_ready); end
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL ripple_latency_early: got out_valid=%b expected 0", out_valid); end
    @(posedge clk); @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL ripple_latency: got out_valid=%b expected 1", out_valid); end
    checks++;
    if ({sum, cout, ovf} !== {32'h0, 1'b1, 1'b0}) begin
      failures++; $display("FAIL ripple_result: got sum=%h cout=%b ovf=%b expected 00000000 1 0", sum, cout, ovf);
    end
    @(posedge clk); @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL ripple_no_dup: got out_valid=%b expected 0", out_valid); end
  endtask

  task automatic test_overflow();
    logic [31:0] exp_s;
`ifdef CLA_SAT_EN
    exp_s = 32'h7FFF_FFFF;
`else
    exp_s = 32'h8000_0000;
`endif
    out_ready = 1'b1; in_valid = 1'b1; a = 32'h7FFF_FFFF; b = 32'h1; cin = 1'b0; sub = 1'b0;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || {sum, cout, ovf} !== {exp_s, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL overflow: got valid=%b sum=%h cout=%b ovf=%b expected 1 %h 0 1", out_valid, sum, cout, ovf, exp_s);
    end
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_subtract();
    out_ready = 1'b1; in_valid = 1'b1; sub = 1'b1; cin = 1'b1; a = 32'd5; b = 32'd7;
    @(posedge clk); @(negedge clk);
    a = 32'd7; b = 32'd5; cin = 1'b0;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0; sub = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || {sum, cout, ovf} !== {32'hFFFF_FFFE, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL sub_5_minus_7: got valid=%b sum=%h cout=%b ovf=%b expected 1 fffffffe 0 0", out_valid, sum, cout, ovf);
    end
    @(posedge clk); @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || {sum, cout, ovf} !== {32'd2, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL sub_7_minus_5: got valid=%b sum=%h cout=%b ovf=%b expected 1 00000002 1 0", out_valid, sum, cout, ovf);
    end
    @(posedge clk); @(negedge clk);
  endtask

  task automatic run_stream(input string tag, input int nbeats, input bit bp_window, input int budget);
    int cyc, sent, recv, nq;
    bit ovs, ir, got, emp, acc, hold, saw_ir0, orr;
    res32_t obs, expv, prev;
    cyc = 0; sent = 0; recv = 0; hold = 1'b0; saw_ir0 = 1'b0; prev = '0;
    while ((sent < nbeats || q32.size() != 0) && cyc < budget) begin
      if (bp_window) out_ready = !(cyc >= 3 && cyc <= 7);
      else out_ready = ($urandom_range(0, 3) != 0);
      orr = out_ready;
      in_valid = (sent < nbeats) && (bp_window || $urandom_range(0, 3) != 0);
      a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
      step32(ovs, ir, obs, got, emp, expv, acc, nq);
      if (acc) sent++;
      checks++;
      if (ir !== ((nq < 2) || orr)) begin
        failures++; $display("FAIL %s_in_ready: cycle %0d got %b expected %b", tag, cyc, ir, (nq < 2) || orr);
      end
      if (!ir) saw_ir0 = 1'b1;
      if (hold) begin
        checks++;
        if (!ovs || obs !== prev) begin
          failures++; $display("FAIL %s_hold: cycle %0d got valid=%b %h expected valid=1 %h", tag, cyc, ovs, obs, prev);
        end
      end
      hold = ovs && !orr;
      prev = obs;
      if (got) begin
        recv++;
        checks++;
        if (emp || obs !== expv) begin
          failures++; $display("FAIL %s_result: beat %0d got %h expected %h (stale=%b)", tag, recv, obs, expv, emp);
        end
      end
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++;
    if (recv != nbeats || cyc >= budget) begin
      failures++; $display("FAIL %s_count: got %0d beats in %0d cycles expected %0d", tag, recv, cyc, nbeats);
    end
    if (bp_window) begin
      checks++;
      if (!saw_ir0) begin failures++; $display("FAIL %s_stall: got in_ready never 0 expected a stall", tag); end
    end
  endtask

  task automatic test_backpressure();
    run_stream("backpressure", 10, 1'b1, 100);
  endtask

  task automatic test_random_stream();
    run_stream("random", 300, 1'b0, 3000);
  endtask

  task automatic test_reset_midflight();
    bit ovs, ir, got, emp, acc;
    int nq;
    res32_t obs, expv;
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; a = $urandom; b = $urandom; cin = 1'b0; sub = 1'b0;
      step32(ovs, ir, obs, got, emp, expv, acc, nq);
      checks++;
      if (!acc) begin failures++; $display("FAIL midflight_accept: beat %0d got accepted=0 expected 1", i); end
    end
    in_valid = 1'b1; rst = 1'b1;
    step32(ovs, ir, obs, got, emp, expv, acc, nq);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || {sum, cout, ovf} !== 34'd0) begin
      failures++; $display("FAIL midflight_cleared: got valid=%b sum=%h cout=%b ovf=%b expected 0 0 0 0", out_valid, sum, cout, ovf);
    end
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL midflight_in_ready: got %b expected 1", in_ready); end
    for (int i = 0; i < 5; i++) begin
      step32(ovs, ir, obs, got, emp, expv, acc, nq);
      checks++;
      if (ovs !== 1'b0) begin failures++; $display("FAIL midflight_stale: cycle %0d got out_valid=%b expected 0", i, ovs); end
    end
  endtask

  task automatic test_w4_exhaustive();
    int sent, recv, cyc, tot, sa, sb, sr;
    logic [5:0] e, got6;
    logic [3:0] s;
    sent = 0; recv = 0; cyc = 0;
    out_ready4 = 1'b1; sub4 = 1'b0;
    while ((sent < 512 || q4.size() != 0) && cyc < 700) begin
      in_valid4 = (sent < 512);
      {cin4, b4, a4} = sent[8:0];
      #1;
      if (in_valid4) begin
        checks++;
        if (in_ready4 !== 1'b1) begin failures++; $display("FAIL w4_throughput: cycle %0d got in_ready=%b expected 1", cyc, in_ready4); end
      end
      if (out_valid4) begin
        recv++;
        got6 = {ovf4, cout4, sum4};
        checks++;
        if (q4.size() == 0) begin
          failures++; $display("FAIL w4_result: got %b with nothing outstanding expected none", got6);
        end else begin
          e = q4.pop_front();
          if (got6 !== e) begin failures++; $display("FAIL w4_result: beat %0d got %b expected %b", recv, got6, e); end
        end
      end
      if (in_valid4 && in_ready4) begin
        tot = int'(a4) + int'(b4) + int'(cin4);
        sa = int'($signed(a4));
        sb = int'($signed(b4));
        sr = sa + sb + int'(cin4);
        s = tot[3:0];
`ifdef CLA_SAT_EN
        if (sr > 7) s = 4'h7;
        else if (sr < -8) s = 4'h8;
`endif
        q4.push_back({(sr > 7) || (sr < -8), tot[4], s});
        sent++;
      end
      @(posedge clk); @(negedge clk);
      cyc++;
    end
    in_valid4 = 1'b0;
    checks++;
    if (recv != 512 || cyc >= 700) begin
      failures++; $display("FAIL w4_count: got %0d results in %0d cycles expected 512", recv, cyc);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    in_valid4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0; sub4 = 1'b0; out_ready4 = 1'b1;
    @(negedge clk);
    test_reset();
    test_ripple();
    test_overflow();
    test_subtract();
    test_backpressure();
    test_reset_midflight();
    test_random_stream();
    test_w4_exhaustive();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
